// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump engine and its debug stream consumers.
package regfile_dump_pkg;

    // Dump engine control states.
    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StRead,
        StSend,
        StFin
    } state_e;

    localparam int unsigned DataW   = 32;
    // Index field wide enough for any register file a consumer is expected to see.
    localparam int unsigned RecIdxW = 8;

    // One dumped register as seen on the debug/trace stream.
    typedef struct packed {
        logic [RecIdxW-1:0] idx;
        logic [DataW-1:0]   data;
        logic               last;
    } dump_rec_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug register-file reader: halts the core, walks every register index through one
// asynchronous read port and streams {index, data} records on a valid/ready interface.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned IDXW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             halt_req,
    input  logic             halted,
    output logic [IDXW-1:0]  rf_raddr,
    input  logic [DataW-1:0] rf_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic [DataW-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    localparam logic [IDXW-1:0] LastIdx = IDXW'(NREGS - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic [DataW-1:0] out_data_q, out_data_d;
    logic             halt_req_q, halt_req_d;
    logic             abort_q, abort_d;

    // State, walk counter, captured record and halt request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            halt_req_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            halt_req_q <= halt_req_d;
            abort_q    <= abort_d;
        end
    end

    // Next-state logic: halt, then one read and one send cycle per register.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        abort_d    = abort_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHalt;
                    idx_d   = '0;
                    abort_d = 1'b0;
                end
            end
            StHalt: begin
                if (halted) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (!halted) begin
                    state_d = StFin;
                    abort_d = 1'b1;
                end else begin
                    out_idx_d  = idx_q;
                    out_data_d = rf_rdata;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (!halted) begin
                    state_d = StFin;
                    abort_d = 1'b1;
                end else if (out_ready) begin
                    // Terminal compare comes first so the counter never wraps.
                    if (idx_q == LastIdx) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + IDXW'(1);
                        state_d = StRead;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                abort_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        halt_req_d = (state_d == StHalt) || (state_d == StRead) || (state_d == StSend);
    end

    // Outputs decoded from registered state; valid is withdrawn as soon as the core un-halts.
    always_comb begin
        out_valid = (state_q == StSend) && halted;
        out_last  = (state_q == StSend) && (out_idx_q == LastIdx);
        rf_raddr  = (state_q == StRead) ? idx_q : '0;
        done      = (state_q == StFin);
        abort     = (state_q == StFin) && abort_q;
        busy      = (state_q != StIdle);
        halt_req  = halt_req_q;
        out_idx   = out_idx_q;
        out_data  = out_data_q;
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: scenario table, randomized dumps and reset corners.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int unsigned NREGS   = 16;
    localparam int unsigned IDXW    = $clog2(NREGS);
    localparam int          TIMEOUT = 400;

    typedef struct {
        int mode;         // 0: ready always, 1: ready 1-0-0-1, 2: random ready
        int hold;         // cycles after start with halted forced low
        int abort_after;  // drop halted after this index is accepted (-1: never)
        int restart_at;   // pulse start while this index is presented (-1: never)
        int exp_nrec;
        bit exp_abort;
        int exp_done;     // done cycle offset from start (0: not checked)
    } vec_t;

    logic             clk = 1'b0;
    logic             rst, start, halted, out_ready;
    logic             halt_req, out_valid, out_last, busy, done, abort;
    logic [IDXW-1:0]  rf_raddr, out_idx;
    logic [31:0]      rf_rdata, out_data;
    logic             halt_dly   = 1'b0;
    logic             halt_block = 1'b0;
    logic [31:0]      regs [NREGS];
    int               cyc    = 0;
    int               errors = 0;
    int               checks = 0;

    // Monitor state
    dump_rec_t        got_q[$];
    int               done_cnt = 0;
    int               done_cyc = 0;
    logic             done_abort = 1'b0;
    logic             chk_busy_next = 1'b0;
    logic             presented [NREGS];
    logic             stall_prev = 1'b0;
    logic [IDXW-1:0]  stall_idx;
    logic [31:0]      stall_data;
    logic             stall_last;
    logic             hold_chk = 1'b0;
    int               last_acc = -1;

    vec_t             vecs [6];

    regfile_dump #(.NREGS(NREGS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halt_req  (halt_req),
        .halted    (halted),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .abort     (abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Core model: acknowledges the halt one cycle after it is requested.
    always @(posedge clk) halt_dly <= halt_req;
    assign halted   = halt_dly & ~halt_block;
    assign rf_rdata = (rf_raddr == '0) ? 32'h0 : regs[rf_raddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream monitor sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) presented[out_idx] = 1'b1;
            if (stall_prev && out_valid === 1'b1)
                check("stall_stable", {out_idx, out_data, out_last},
                      {stall_idx, stall_data, stall_last});
            stall_prev = (out_valid === 1'b1) && !out_ready;
            stall_idx  = out_idx;
            stall_data = out_data;
            stall_last = out_last;
            last_acc   = -1;
            if (out_valid === 1'b1 && out_ready) begin
                got_q.push_back('{idx: RecIdxW'(out_idx), data: out_data, last: out_last});
                last_acc = int'(out_idx);
            end
            if (chk_busy_next) begin
                check("busy_after_done", busy, 0);
                chk_busy_next = 1'b0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc   = cyc;
                done_abort = abort;
                check("halt_req_in_fin", halt_req, 0);
                chk_busy_next = 1'b1;
            end
            if (hold_chk)
                check("hold_quiet", {halt_req, out_valid, rf_raddr}, {1'b1, 1'b0, 4'h0});
        end
    end

    task automatic run_dump(input int mode, input int hold, input int abort_after,
                            input int restart_at, output int start_cyc);
        bit aborting  = 1'b0;
        bit restarted = 1'b0;
        int k;
        got_q.delete();
        done_cnt   = 0;
        stall_prev = 1'b0;
        for (int i = 0; i < NREGS; i++) presented[i] = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        start_cyc = cyc;
        for (k = 1; k <= TIMEOUT && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (restart_at >= 0 && !restarted && out_valid && int'(out_idx) == restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (abort_after >= 0 && last_acc == abort_after) aborting = 1'b1;
            halt_block = (k <= hold) || aborting;
            hold_chk   = (k <= hold) && !aborting;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        check("timeout", done_cnt != 0, 1);
        @(negedge clk); #1;
        halt_block = 1'b0;
        hold_chk   = 1'b0;
        start      = 1'b0;
    endtask

    // Reference: records 0..n-1 in order, x0 reads 0, last only on the final index.
    task automatic check_run(input int exp_nrec, input bit exp_abort, input int exp_done,
                             input int start_cyc, input int abort_after);
        dump_rec_t e;
        check("rec_count", 64'(got_q.size()), 64'(exp_nrec));
        for (int i = 0; i < got_q.size() && i < exp_nrec; i++) begin
            e.idx  = RecIdxW'(i);
            e.data = (i == 0) ? 32'h0 : regs[i];
            e.last = (i == NREGS - 1);
            check($sformatf("rec%0d", i), 64'(got_q[i]), 64'(e));
        end
        check("done_count", 64'(done_cnt), 1);
        check("abort_flag", done_abort, exp_abort);
        if (exp_done != 0) check("done_cycle", 64'(done_cyc - start_cyc), 64'(exp_done));
        if (abort_after >= 0) check("next_not_presented", presented[abort_after + 1], 0);
    endtask

    initial begin
        int  sc;
        int  hold;
        int  aa;
        bit  found;

        vecs[0] = '{0,  0, -1, -1, 16, 1'b0, 35};
        vecs[1] = '{1,  0, -1, -1, 16, 1'b0,  0};
        vecs[2] = '{0, 10, -1, -1, 16, 1'b0, 44};
        vecs[3] = '{0,  0,  5, -1,  6, 1'b1, 16};
        vecs[4] = '{0,  0, -1,  3, 16, 1'b0, 35};
        vecs[5] = '{2,  3, -1, -1, 16, 1'b0,  0};
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h100 + 32'(i);

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {halt_req, out_valid, out_last, busy, done, abort, rf_raddr, out_idx, out_data}, 0);

        // start together with rst: rst wins
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        check("rst_beats_start", {busy, halt_req}, 0);
        @(posedge clk); #1;
        check("still_idle", busy, 0);

        foreach (vecs[v]) begin
            run_dump(vecs[v].mode, vecs[v].hold, vecs[v].abort_after, vecs[v].restart_at, sc);
            check_run(vecs[v].exp_nrec, vecs[v].exp_abort, vecs[v].exp_done, sc,
                      vecs[v].abort_after);
        end

        // Reset while idx 7 is being presented, then a clean dump from idx 0.
        got_q.delete();
        done_cnt = 0;
        found    = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < TIMEOUT && !found; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid && out_idx == 4'd7) found = 1'b1;
        end
        check("reach_idx7", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs",
              {halt_req, out_valid, out_last, busy, done, abort, rf_raddr, out_idx, out_data}, 0);
        rst = 1'b0;
        check("rst_no_done", 64'(done_cnt), 0);
        run_dump(0, 0, -1, -1, sc);
        check_run(16, 1'b0, 35, sc, -1);

        // Randomized register contents, backpressure, halt delay and aborts.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
            hold = int'($urandom_range(0, 4));
            aa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NREGS - 2)) : -1;
            run_dump(2, hold, aa, -1, sc);
            check_run((aa >= 0) ? aa + 1 : NREGS, aa >= 0, 0, sc, aa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
